memory_access_stage: RTL and testbench
======================================

// Module: memory_access_stage
// PURPOSE
//  Memory stage between execute and write_buffer_pc_generate. Accepts one instruction token
//  (distinct pulse) plus execute results, performs at most one data-memory load or store, and
//  re-issues the token with all fields registered and read_data filled in. Variable latency
//  (ALU-only / store / load) is hidden behind the distinct handshake.
// PARAMETERS
//  INST_MEM_WIDTH  5   instruction address width (pc, pc1, pc2)
//  DATA_MEM_WIDTH  10  data-memory word address width
//  MEM_LATENCY     2   data-memory read latency in cycles (>=1)
// PORTS
//  CLK            in   1   clock
//  reset          in   1   synchronous, active-high reset
//  distinct       in   1   token valid from execute, 1-cycle pulse
//  AorF,RegWrite  in   1   passed through
//  MemtoReg       in   2   passed through
//  Branch         in   2   passed through
//  UARTtoReg      in   1   passed through
//  MemRead        in   1   load
//  MemWrite       in   1   store
//  alu_result     in   32  ALU result / memory address
//  register_data  in   32  store data / jr target
//  rd             in   5   destination register
//  inst_index     in   26  jump index
//  pc,pc1,pc2     in   INST_MEM_WIDTH  pass-through PCs
//  mem_addr       out  DATA_MEM_WIDTH  data-memory address (registered)
//  mem_wdata      out  32  store data (registered)
//  mem_we         out  1   store strobe, 1 cycle
//  mem_re         out  1   read request, 1 cycle
//  mem_rdata      in   32  read data, valid MEM_LATENCY cycles after mem_re
//  distinct_next  out  1   token to write_buffer_pc_generate, 1-cycle pulse
//  *_next         out  --  registered copies of every pass-through field, same widths
//  read_data      out  32  load result (0 for non-loads)
//  overrun        out  1   sticky: token arrived while busy
// BEHAVIOUR
//  Reset: distinct_next=0, mem_we=0, mem_re=0, overrun=0, read_data=0, all *_next=0
//   except Branch_next=2'b11; state=IDLE, wait counter=0.
//  FSM: IDLE, STORE, LOAD_WAIT, EMIT. Cycle 0 = edge where distinct sampled high in IDLE.
//  IDLE+distinct: capture all fields into *_next, mem_addr=alu_result[DATA_MEM_WIDTH-1:0]
//   (silent truncation, upper bits ignored), mem_wdata=register_data.
//   MemWrite -> STORE (mem_we=1 in cycle 1); else MemRead -> LOAD_WAIT (mem_re=1 in cycle 1,
//   counter=MEM_LATENCY); else -> EMIT with read_data=0.
//  MemRead&MemWrite both high: store only, read_data=0.
//  STORE: mem_we drops, -> EMIT; distinct_next high cycle 2.
//  LOAD_WAIT: counter decrements each cycle; at 1 capture read_data<=mem_rdata, -> EMIT;
//   distinct_next high cycle MEM_LATENCY+1.
//  ALU-only: distinct_next high cycle 1.
//  EMIT: distinct_next=1 one cycle, -> IDLE. distinct in EMIT is accepted as a new token
//   (back-to-back, 1 token/2 cycles min).
//  *_next and read_data stay stable from emit until next token captured.
//  distinct high in STORE/LOAD_WAIT: token dropped, overrun<=1 (cleared only by reset).
//  Reset mid-load/store: FSM to IDLE immediately, no distinct_next, mem_we/mem_re low next cycle.
// STRUCTURE
//  Shared package cpu_pkg: mem_state_t enum, MemtoReg/Branch encodings, BRANCH_NONE=2'b11.
//  One sub-module: load_wait_counter (load, decrement, done flag; width $clog2(MEM_LATENCY+1)).
// TESTING
//  ALU op alu_result=5,rd=3 -> distinct_next cycle 1, rd_next=3, read_data=0, mem_we/re=0.
//  Store alu_result=0x10,register_data=0xDEADBEEF -> mem_we cycle 1, addr 0x10, distinct_next cycle 2.
//  Load addr 0x10 after above, MEM_LATENCY=2 -> mem_re cycle 1, read_data=0xDEADBEEF, pulse cycle 3.
//  alu_result=0x0000_0410 -> mem_addr=0x010 (truncation); Read&Write both -> store only.
//  distinct during LOAD_WAIT -> overrun=1, only one distinct_next; EMIT-cycle distinct accepted.
//  Reset asserted in LOAD_WAIT -> no distinct_next, Branch_next=2'b11, all others 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared pipeline types: memory-stage FSM states and control-field encodings.
package cpu_pkg;

  typedef enum logic [1:0] {
    S_IDLE      = 2'b00,
    S_STORE     = 2'b01,
    S_LOAD_WAIT = 2'b10,
    S_EMIT      = 2'b11
  } mem_state_t;

  localparam logic [1:0] MEMTOREG_ALU = 2'b00;
  localparam logic [1:0] MEMTOREG_MEM = 2'b01;
  localparam logic [1:0] MEMTOREG_PC  = 2'b10;

  localparam logic [1:0] BRANCH_BEQ  = 2'b00;
  localparam logic [1:0] BRANCH_BNE  = 2'b01;
  localparam logic [1:0] BRANCH_JUMP = 2'b10;
  localparam logic [1:0] BRANCH_NONE = 2'b11;

endpackage

// File: rtl/load_wait_counter.sv
// Counts down the data-memory read latency; done_c marks the cycle read data is sampled.
module load_wait_counter #(
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic CLK,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic done_c
);

  localparam int unsigned CNT_W = $clog2(MEM_LATENCY + 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge CLK) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= CNT_W'(MEM_LATENCY);
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign done_c = (count == CNT_W'(1));

endmodule

// File: rtl/memory_access_stage.sv
// Memory stage: takes one token from execute, does at most one load or store,
// and re-issues the token with registered fields and read_data filled in.
module memory_access_stage
  import cpu_pkg::*;
#(
  parameter int unsigned INST_MEM_WIDTH = 5,
  parameter int unsigned DATA_MEM_WIDTH = 10,
  parameter int unsigned MEM_LATENCY    = 2
) (
  input  logic                      CLK,
  input  logic                      reset,
  input  logic                      distinct,
  input  logic                      AorF,
  input  logic                      RegWrite,
  input  logic [1:0]                MemtoReg,
  input  logic [1:0]                Branch,
  input  logic                      UARTtoReg,
  input  logic                      MemRead,
  input  logic                      MemWrite,
  input  logic [31:0]               alu_result,
  input  logic [31:0]               register_data,
  input  logic [4:0]                rd,
  input  logic [25:0]               inst_index,
  input  logic [INST_MEM_WIDTH-1:0] pc,
  input  logic [INST_MEM_WIDTH-1:0] pc1,
  input  logic [INST_MEM_WIDTH-1:0] pc2,
  output logic [DATA_MEM_WIDTH-1:0] mem_addr,
  output logic [31:0]               mem_wdata,
  output logic                      mem_we,
  output logic                      mem_re,
  input  logic [31:0]               mem_rdata,
  output logic                      distinct_next,
  output logic                      AorF_next,
  output logic                      RegWrite_next,
  output logic [1:0]                MemtoReg_next,
  output logic [1:0]                Branch_next,
  output logic                      UARTtoReg_next,
  output logic                      MemRead_next,
  output logic                      MemWrite_next,
  output logic [31:0]               alu_result_next,
  output logic [31:0]               register_data_next,
  output logic [4:0]                rd_next,
  output logic [25:0]               inst_index_next,
  output logic [INST_MEM_WIDTH-1:0] pc_next,
  output logic [INST_MEM_WIDTH-1:0] pc1_next,
  output logic [INST_MEM_WIDTH-1:0] pc2_next,
  output logic [31:0]               read_data,
  output logic                      overrun
);

  mem_state_t state, next_state;
  logic       accept_c;
  logic       drop_c;
  logic       start_load_c;
  logic       load_done_c;

  load_wait_counter #(.MEM_LATENCY(MEM_LATENCY)) u_load_wait_counter (
    .CLK    (CLK),
    .reset  (reset),
    .load   (start_load_c),
    .dec    (state == S_LOAD_WAIT),
    .done_c (load_done_c)
  );

  always_ff @(posedge CLK) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // EMIT doubles as an accepting state so tokens can arrive every other cycle.
  always_comb begin
    next_state = state;
    accept_c   = 1'b0;
    drop_c     = 1'b0;
    case (state)
      S_IDLE, S_EMIT: begin
        next_state = S_IDLE;
        if (distinct) begin
          accept_c = 1'b1;
          if (MemWrite)     next_state = S_STORE;
          else if (MemRead) next_state = S_LOAD_WAIT;
          else              next_state = S_EMIT;
        end
      end
      S_STORE: begin
        drop_c     = distinct;
        next_state = S_EMIT;
      end
      S_LOAD_WAIT: begin
        drop_c = distinct;
        if (load_done_c) next_state = S_EMIT;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // A simultaneous read and write request is treated as a store only.
  assign start_load_c = accept_c && MemRead && !MemWrite;

  always_ff @(posedge CLK) begin
    if (reset) begin
      distinct_next      <= 1'b0;
      mem_we             <= 1'b0;
      mem_re             <= 1'b0;
      mem_addr           <= '0;
      mem_wdata          <= '0;
      overrun            <= 1'b0;
      read_data          <= '0;
      AorF_next          <= 1'b0;
      RegWrite_next      <= 1'b0;
      MemtoReg_next      <= '0;
      Branch_next        <= BRANCH_NONE;
      UARTtoReg_next     <= 1'b0;
      MemRead_next       <= 1'b0;
      MemWrite_next      <= 1'b0;
      alu_result_next    <= '0;
      register_data_next <= '0;
      rd_next            <= '0;
      inst_index_next    <= '0;
      pc_next            <= '0;
      pc1_next           <= '0;
      pc2_next           <= '0;
    end else begin
      distinct_next <= (next_state == S_EMIT);
      mem_we        <= accept_c && MemWrite;
      mem_re        <= start_load_c;
      if (drop_c) overrun <= 1'b1;
      if (accept_c) begin
        mem_addr           <= alu_result[DATA_MEM_WIDTH-1:0];
        mem_wdata          <= register_data;
        read_data          <= '0;
        AorF_next          <= AorF;
        RegWrite_next      <= RegWrite;
        MemtoReg_next      <= MemtoReg;
        Branch_next        <= Branch;
        UARTtoReg_next     <= UARTtoReg;
        MemRead_next       <= MemRead;
        MemWrite_next      <= MemWrite;
        alu_result_next    <= alu_result;
        register_data_next <= register_data;
        rd_next            <= rd;
        inst_index_next    <= inst_index;
        pc_next            <= pc;
        pc1_next           <= pc1;
        pc2_next           <= pc2;
      end
      if ((state == S_LOAD_WAIT) && load_done_c) read_data <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed bench for memory_access_stage with a small behavioural data memory.
module tb_memory_access_stage;

  localparam int unsigned IW = 5;
  localparam int unsigned DW = 10;

  logic          CLK = 1'b0;
  logic          reset, distinct, AorF, RegWrite, UARTtoReg, MemRead, MemWrite;
  logic [1:0]    MemtoReg, Branch;
  logic [31:0]   alu_result, register_data, mem_rdata, mem_wdata;
  logic [4:0]    rd, rd_next;
  logic [25:0]   inst_index, inst_index_next;
  logic [IW-1:0] pc, pc1, pc2, pc_next, pc1_next, pc2_next;
  logic [DW-1:0] mem_addr;
  logic          mem_we, mem_re, distinct_next, AorF_next, RegWrite_next, UARTtoReg_next;
  logic          MemRead_next, MemWrite_next, overrun;
  logic [1:0]    MemtoReg_next, Branch_next;
  logic [31:0]   alu_result_next, register_data_next, read_data;

  logic [31:0]   mem [0:(1<<DW)-1];
  int            errors = 0;
  int            checks = 0;

  always #5 CLK = ~CLK;

  memory_access_stage #(.INST_MEM_WIDTH(IW), .DATA_MEM_WIDTH(DW), .MEM_LATENCY(2)) dut (
    .CLK(CLK), .reset(reset), .distinct(distinct), .AorF(AorF), .RegWrite(RegWrite),
    .MemtoReg(MemtoReg), .Branch(Branch), .UARTtoReg(UARTtoReg), .MemRead(MemRead),
    .MemWrite(MemWrite), .alu_result(alu_result), .register_data(register_data), .rd(rd),
    .inst_index(inst_index), .pc(pc), .pc1(pc1), .pc2(pc2), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata),
    .distinct_next(distinct_next), .AorF_next(AorF_next), .RegWrite_next(RegWrite_next),
    .MemtoReg_next(MemtoReg_next), .Branch_next(Branch_next), .UARTtoReg_next(UARTtoReg_next),
    .MemRead_next(MemRead_next), .MemWrite_next(MemWrite_next),
    .alu_result_next(alu_result_next), .register_data_next(register_data_next),
    .rd_next(rd_next), .inst_index_next(inst_index_next), .pc_next(pc_next),
    .pc1_next(pc1_next), .pc2_next(pc2_next), .read_data(read_data), .overrun(overrun)
  );

  // Data memory: data registered one edge after the request, sampled by the DUT the next edge.
  always @(posedge CLK) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Present a token; returns one cycle after the sampling edge (cycle 1) with distinct low.
  task automatic send(input logic mr, input logic mw, input logic [31:0] alu,
                      input logic [31:0] wd, input logic [4:0] r, input logic [1:0] br);
    MemRead = mr; MemWrite = mw; alu_result = alu; register_data = wd; rd = r; Branch = br;
    distinct = 1'b1;
    tick();
    distinct = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    checks++; if (distinct_next !== 1'b0) begin errors++; $display("FAIL rst_distinct: got %b want 0", distinct_next); end
    checks++; if (Branch_next !== 2'b11) begin errors++; $display("FAIL rst_branch: got %b want 11", Branch_next); end
    checks++; if ({mem_we, mem_re, overrun} !== 3'b000) begin errors++; $display("FAIL rst_strobes: got %b want 000", {mem_we, mem_re, overrun}); end
    checks++; if ({read_data, rd_next, pc_next} !== '0) begin errors++; $display("FAIL rst_fields: got %h/%h/%h want 0", read_data, rd_next, pc_next); end
  endtask

  task automatic test_alu();
    send(1'b0, 1'b0, 32'd5, 32'h0, 5'd3, 2'b00);
    checks++; if (distinct_next !== 1'b1) begin errors++; $display("FAIL alu_pulse: got %b want 1", distinct_next); end
    checks++; if (rd_next !== 5'd3) begin errors++; $display("FAIL alu_rd: got %0d want 3", rd_next); end
    checks++; if (read_data !== 32'h0) begin errors++; $display("FAIL alu_rdata: got %h want 0", read_data); end
    checks++; if ({mem_we, mem_re} !== 2'b00) begin errors++; $display("FAIL alu_mem: got %b want 00", {mem_we, mem_re}); end
    checks++; if ({alu_result_next, Branch_next, pc_next, inst_index_next} !== {32'd5, 2'b00, 5'h1a, 26'h155_5555})
      begin errors++; $display("FAIL alu_fields: got %h %b %h %h", alu_result_next, Branch_next, pc_next, inst_index_next); end
    tick();
    checks++; if (distinct_next !== 1'b0) begin errors++; $display("FAIL alu_pulse_end: got %b want 0", distinct_next); end
  endtask

  task automatic test_store();
    send(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 5'd4, 2'b00);
    checks++; if ({mem_we, distinct_next} !== 2'b10) begin errors++; $display("FAIL st_c1: got we,dn=%b want 10", {mem_we, distinct_next}); end
    checks++; if ({mem_addr, mem_wdata} !== {10'h010, 32'hDEADBEEF}) begin errors++; $display("FAIL st_bus: got %h %h want 010 deadbeef", mem_addr, mem_wdata); end
    tick();
    checks++; if ({mem_we, distinct_next} !== 2'b01) begin errors++; $display("FAIL st_c2: got we,dn=%b want 01", {mem_we, distinct_next}); end
    tick();
    checks++; if (distinct_next !== 1'b0) begin errors++; $display("FAIL st_c3: got %b want 0", distinct_next); end
  endtask

  task automatic test_load();
    send(1'b1, 1'b0, 32'h10, 32'h0, 5'd9, 2'b01);
    checks++; if ({mem_re, distinct_next} !== 2'b10) begin errors++; $display("FAIL ld_c1: got re,dn=%b want 10", {mem_re, distinct_next}); end
    tick();
    checks++; if ({mem_re, distinct_next} !== 2'b00) begin errors++; $display("FAIL ld_c2: got re,dn=%b want 00", {mem_re, distinct_next}); end
    tick();
    checks++; if (distinct_next !== 1'b1) begin errors++; $display("FAIL ld_c3_pulse: got %b want 1", distinct_next); end
    checks++; if (read_data !== 32'hDEADBEEF) begin errors++; $display("FAIL ld_data: got %h want deadbeef", read_data); end
    tick();
    checks++; if ({distinct_next, read_data, rd_next} !== {1'b0, 32'hDEADBEEF, 5'd9}) begin errors++; $display("FAIL ld_hold: got %b %h %0d", distinct_next, read_data, rd_next); end
  endtask

  task automatic test_trunc_rw();
    send(1'b1, 1'b1, 32'h0000_0410, 32'h1234_5678, 5'd5, 2'b00);
    checks++; if (mem_addr !== 10'h010) begin errors++; $display("FAIL trunc_addr: got %h want 010", mem_addr); end
    checks++; if ({mem_we, mem_re} !== 2'b10) begin errors++; $display("FAIL rw_store_only: got we,re=%b want 10", {mem_we, mem_re}); end
    tick();
    checks++; if ({distinct_next, read_data} !== {1'b1, 32'h0}) begin errors++; $display("FAIL rw_emit: got %b %h want 1 0", distinct_next, read_data); end
    tick();
  endtask

  task automatic test_overrun_back_to_back();
    int pulses;
    send(1'b1, 1'b0, 32'h10, 32'h0, 5'd9, 2'b01);
    MemRead = 1'b0; alu_result = 32'h99; rd = 5'd7; distinct = 1'b1;
    tick();
    distinct = 1'b0;
    checks++; if ({overrun, distinct_next, mem_re} !== 3'b100) begin errors++; $display("FAIL ovr_c2: got ovr,dn,re=%b want 100", {overrun, distinct_next, mem_re}); end
    tick();
    checks++; if ({distinct_next, read_data, rd_next} !== {1'b1, 32'h1234_5678, 5'd9}) begin errors++; $display("FAIL ovr_emit: got %b %h %0d", distinct_next, read_data, rd_next); end
    send(1'b0, 1'b0, 32'h77, 32'h0, 5'd12, 2'b10);
    checks++; if ({distinct_next, rd_next, alu_result_next, read_data} !== {1'b1, 5'd12, 32'h77, 32'h0})
      begin errors++; $display("FAIL b2b_accept: got %b %0d %h %h", distinct_next, rd_next, alu_result_next, read_data); end
    pulses = 0;
    for (int i = 0; i < 4; i++) begin tick(); if (distinct_next) pulses++; end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL ovr_extra_pulses: got %0d want 0", pulses); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
  endtask

  task automatic test_reset_mid_load();
    int pulses;
    send(1'b1, 1'b0, 32'h10, 32'h0, 5'd9, 2'b01);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if ({distinct_next, mem_re, mem_we, overrun} !== 4'b0000) begin errors++; $display("FAIL rml_strobes: got %b want 0000", {distinct_next, mem_re, mem_we, overrun}); end
    checks++; if ({Branch_next, rd_next, read_data, alu_result_next} !== {2'b11, 5'd0, 32'h0, 32'h0})
      begin errors++; $display("FAIL rml_fields: got %b %0d %h %h", Branch_next, rd_next, read_data, alu_result_next); end
    pulses = 0;
    for (int i = 0; i < 4; i++) begin tick(); if (distinct_next) pulses++; end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL rml_no_pulse: got %0d want 0", pulses); end
    send(1'b0, 1'b0, 32'h3, 32'h0, 5'd21, 2'b00);
    checks++; if ({distinct_next, rd_next} !== {1'b1, 5'd21}) begin errors++; $display("FAIL rml_resume: got %b %0d", distinct_next, rd_next); end
  endtask

  initial begin
    reset = 1'b1; distinct = 1'b0; AorF = 1'b1; RegWrite = 1'b1; UARTtoReg = 1'b0;
    MemtoReg = 2'b01; Branch = 2'b00; MemRead = 1'b0; MemWrite = 1'b0;
    alu_result = '0; register_data = '0; rd = '0; inst_index = 26'h155_5555;
    pc = 5'h1a; pc1 = 5'h1b; pc2 = 5'h1c; mem_rdata = '0;
    test_reset();
    test_alu();
    test_store();
    test_load();
    test_trunc_rw();
    test_overrun_back_to_back();
    test_reset_mid_load();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
